// File: rtl/issue_scoreboard.sv
// Issue stage: checks RAW/WAW hazards against a pending-write scoreboard and
// holds one instruction for execute. Optional stall counter: ISSUE_STALL_COUNT_EN.
module issue_scoreboard #(
    parameter int NREGS = 32,
    parameter int REGW  = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [1:0]      in_numop,
    input  logic            in_writereg,
    input  logic            in_selregdest,
    input  logic            in_writemem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [REGW-1:0] out_dest,
    output logic            out_writereg,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_reg,
    input  logic            flush,
`ifdef ISSUE_STALL_COUNT_EN
    output logic [31:0]     stall_count,
`endif
    output logic            hazard_stall
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [REGW-1:0]  out_dest_q, out_dest_d;
    logic             out_writereg_q, out_writereg_d;

    logic [REGW-1:0]  rs, rt, rd, dest;
    logic [NREGS-1:0] wb_mask, eff_pending;
    logic             eff_write, chk_rs, chk_rt, hazard;
    logic             accept, consume;

    assign rs   = in_instr[25:21];
    assign rt   = in_instr[20:16];
    assign rd   = in_instr[15:11];
    assign dest = in_selregdest ? rd : rt;

    assign eff_write = in_writereg && (dest != '0);
    assign chk_rs    = (in_numop != 2'b00);
    assign chk_rt    = in_numop[1] || in_writemem;

    // Same-cycle writeback bypass; bit 0 masked so register 0 never hazards.
    assign wb_mask     = wb_valid ? (NREGS'(1) << wb_reg) : '0;
    assign eff_pending = pending_q & ~wb_mask & ~NREGS'(1);

    assign hazard = (chk_rs && eff_pending[rs])
                  || (chk_rt && eff_pending[rt])
                  || (eff_write && eff_pending[dest]);

    assign hazard_stall = in_valid && hazard;
    assign in_ready     = !hazard && !flush && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign consume      = out_valid_q && out_ready;

    always_comb begin
        pending_d = pending_q;
        if (wb_valid)
            pending_d[wb_reg] = 1'b0;
        // A squashed, unconsumed writer will never write back.
        if (flush && out_valid_q && out_writereg_q && !consume)
            pending_d[out_dest_q] = 1'b0;
        if (accept && eff_write)
            pending_d[dest] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_dest_d     = out_dest_q;
        out_writereg_d = out_writereg_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (consume)
            out_valid_d = 1'b0;
        if (accept) begin
            out_instr_d    = in_instr;
            out_dest_d     = eff_write ? dest : '0;
            out_writereg_d = in_writereg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q      <= '0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_dest_q     <= '0;
            out_writereg_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_dest_q     <= out_dest_d;
            out_writereg_q <= out_writereg_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_dest     = out_dest_q;
    assign out_writereg = out_writereg_q;

`ifdef ISSUE_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard_stall && !flush && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_count_q <= '0;
        else
            stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: per-cycle model comparison plus literal pins.
module tb_issue_scoreboard;

    localparam logic [31:0] ADDU3    = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] OR4      = 32'h00A6_2025; // or   $4,$5,$6
    localparam logic [31:0] SUBU7    = 32'h0061_3823; // subu $7,$3,$1
    localparam logic [31:0] LW8      = 32'h8C28_0000; // lw   $8,0($1)
    localparam logic [31:0] SW8      = 32'hAC48_0004; // sw   $8,4($2)
    localparam logic [31:0] ADDIU8   = 32'h2428_0005; // addiu $8,$1,5
    localparam logic [31:0] ADDU9    = 32'h0022_4821; // addu $9,$1,$2
    localparam logic [31:0] ADDU10   = 32'h0121_5021; // addu $10,$9,$1
    localparam logic [31:0] ADDU0    = 32'h0022_0021; // addu $0,$1,$2
    localparam logic [31:0] ADDU5_00 = 32'h0000_2821; // addu $5,$0,$0

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [1:0]  in_numop = '0;
    logic        in_writereg = 1'b0;
    logic        in_selregdest = 1'b0;
    logic        in_writemem = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [4:0]  out_dest;
    logic        out_writereg;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic        flush = 1'b0;
    logic        hazard_stall;
`ifdef ISSUE_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    issue_scoreboard dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_numop(in_numop), .in_writereg(in_writereg),
        .in_selregdest(in_selregdest), .in_writemem(in_writemem),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_dest(out_dest), .out_writereg(out_writereg),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
`ifdef ISSUE_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .hazard_stall(hazard_stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          started = 0;
    bit          mpend[32];
    bit          mov;
    logic [31:0] minstr;
    int          mdest;
    bit          mwr;
    longint      mcnt;

    function automatic bit is_pending(int r);
        if (r == 0) return 0;
        if (wb_valid && int'(wb_reg) == r) return 0;
        return mpend[r];
    endfunction

    function automatic int dest_of();
        return in_selregdest ? int'(in_instr[15:11]) : int'(in_instr[20:16]);
    endfunction

    function automatic bit m_hazard();
        int srcs[$];
        int d = dest_of();
        if (in_numop != 2'b00) srcs.push_back(int'(in_instr[25:21]));
        if (in_numop[1] || in_writemem) srcs.push_back(int'(in_instr[20:16]));
        foreach (srcs[k]) if (is_pending(srcs[k])) return 1;
        return (in_writereg && d != 0 && is_pending(d));
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && !flush && (!mov || out_ready);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            foreach (mpend[i]) mpend[i] = 0;
            mov = 0; minstr = '0; mdest = 0; mwr = 0; mcnt = 0;
            started = 1;
        end else if (started) begin
            bit hz, acc, cons;
            int d;
            hz   = m_hazard();
            acc  = in_valid && m_ready();
            cons = mov && out_ready;
            d    = dest_of();
            if (in_valid && hz && !flush && mcnt < 64'hFFFF_FFFF) mcnt++;
            if (wb_valid && wb_reg != 0) mpend[wb_reg] = 0;
            if (flush && mov && mwr && !cons) mpend[mdest] = 0;
            if (acc && in_writereg && d != 0) mpend[d] = 1;
            if (acc) begin
                minstr = in_instr;
                mdest  = (in_writereg && d != 0) ? d : 0;
                mwr    = in_writereg;
            end
            if (flush) mov = 0;
            else if (acc) mov = 1;
            else if (cons) mov = 0;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("in_ready", 32'(in_ready), 32'(m_ready()));
            check("hazard_stall", 32'(hazard_stall), 32'(in_valid && m_hazard()));
            check("out_valid", 32'(out_valid), 32'(mov));
            check("out_instr", out_instr, minstr);
            check("out_dest", 32'(out_dest), 32'(mdest));
            check("out_writereg", 32'(out_writereg), 32'(mwr));
`ifdef ISSUE_STALL_COUNT_EN
            check("stall_count", stall_count, 32'(mcnt));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic v, input logic [31:0] ins, input logic [1:0] nop,
                       input logic wr, input logic sel, input logic wm, input logic ordy,
                       input logic wbv, input logic [4:0] wbr, input logic fl);
        in_valid = v; in_instr = ins; in_numop = nop; in_writereg = wr;
        in_selregdest = sel; in_writemem = wm; out_ready = ordy;
        wb_valid = wbv; wb_reg = wbr; flush = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic wbv, input logic [4:0] wbr);
        drv(0, '0, 2'b00, 0, 0, 0, ordy, wbv, wbr, 0);
    endtask

    initial begin
        idle(1, 0, 0);
        tick(); tick();
        reset = 0;
        idle(1, 0, 0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        tick();

        // back-to-back independent ops, then RAW stall released by bypass
        drv(1, ADDU3, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("b2b_ready0", 32'(in_ready), 32'd1);
        tick();
        drv(1, OR4, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        check("b2b_instr0", out_instr, ADDU3);
        check("b2b_dest0", 32'(out_dest), 32'd3);
        tick();
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("b2b_instr1", out_instr, OR4);
        check("raw_stall", 32'(hazard_stall), 32'd1);
        check("raw_ready", 32'(in_ready), 32'd0);
        tick();
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("raw_stall2", 32'(hazard_stall), 32'd1);
        tick();
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 1, 5'd3, 0);
        check("raw_bypass", 32'(in_ready), 32'd1);
        tick();
        idle(1, 1, 5'd4);
        check("raw_issued", out_instr, SUBU7);
        check("raw_valid", 32'(out_valid), 32'd1);
        tick();
        idle(1, 1, 5'd7);
        tick();

        // store checks rt; WAW on pending $8
        drv(1, LW8, 2'b01, 1, 0, 0, 1, 0, 0, 0);
        tick();
        drv(1, SW8, 2'b01, 0, 0, 1, 1, 0, 0, 0);
        check("sw_stall", 32'(hazard_stall), 32'd1);
        check("sw_ready", 32'(in_ready), 32'd0);
        tick();
        drv(1, ADDIU8, 2'b01, 1, 0, 0, 1, 0, 0, 0);
        check("waw_stall", 32'(hazard_stall), 32'd1);
        tick();
        drv(1, SW8, 2'b01, 0, 0, 1, 1, 1, 5'd8, 0);
        check("sw_bypass", 32'(in_ready), 32'd1);
        tick();
        idle(1, 0, 0);
        check("sw_instr", out_instr, SW8);
        check("sw_dest", 32'(out_dest), 32'd0);
        check("sw_wr", 32'(out_writereg), 32'd0);
        tick();

        // backpressure then no-bubble refill
        drv(1, OR4, 2'b10, 1, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, ADDU3, 2'b10, 1, 1, 0, 0, 0, 0, 0);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_instr", out_instr, OR4);
            check("bp_nohaz", 32'(hazard_stall), 32'd0);
            tick();
        end
        drv(1, ADDU3, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("bp_refill", 32'(in_ready), 32'd1);
        tick();
        idle(1, 1, 5'd4);
        check("bp_new_instr", out_instr, ADDU3);
        check("bp_new_valid", 32'(out_valid), 32'd1);
        tick();
        idle(1, 1, 5'd3);
        tick();

        // flush squashes an unconsumed writer and frees its register
        drv(1, ADDU9, 2'b10, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(0, '0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        check("fl_ready", 32'(in_ready), 32'd0);
        tick();
        drv(1, ADDU10, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_reader", 32'(in_ready), 32'd1);
        tick();
        idle(1, 0, 0);
        check("fl_issued", out_instr, ADDU10);
        tick();
        idle(1, 1, 5'd10);
        tick();

        // reset during a stall
        drv(1, ADDU3, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        tick();
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("rs_stall", 32'(hazard_stall), 32'd1);
        tick();
        reset = 1;
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        tick();
        reset = 0;
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("rs_valid", 32'(out_valid), 32'd0);
        check("rs_ready", 32'(in_ready), 32'd1);
        tick();
        idle(1, 1, 5'd7);
        tick();

        // register 0 is never pending
        drv(1, ADDU0, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        tick();
        drv(1, ADDU5_00, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        check("r0_ready", 32'(in_ready), 32'd1);
        check("r0_nohaz", 32'(hazard_stall), 32'd0);
        check("r0_dest", 32'(out_dest), 32'd0);
        tick();
        idle(1, 0, 0);
        check("r5_dest", 32'(out_dest), 32'd5);
        tick();
        idle(1, 1, 5'd5);
        tick();

`ifdef ISSUE_STALL_COUNT_EN
        reset = 1;
        idle(1, 0, 0);
        tick();
        reset = 0;
        drv(1, ADDU3, 2'b10, 1, 1, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 0, 0, 0);
            tick();
        end
        drv(1, SUBU7, 2'b10, 1, 1, 0, 1, 1, 5'd3, 0);
        check("stall_cnt4", stall_count, 32'd4);
        tick();
        idle(1, 1, 5'd7);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
